// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// Optional statistics counters are enabled by defining ICACHE_STAT_EN.
package icache_pkg;

    localparam int AddressWidth = 32;
    localparam int IDWidth      = 32;
    localparam int INDEX_BITS   = 6;
    localparam int TAG_BITS     = AddressWidth - INDEX_BITS - 2;
    localparam int LINES        = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_MISS  = 2'd1,
        ICACHE_ABORT = 2'd2,
        ICACHE_RESP  = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and RAM-controller-side handshake bundle of the icache.
// slave = cache view, master = fetch stage / RAM controller view.
interface icache_if;
    import icache_pkg::*;

    logic                    if_en_in;
    logic [AddressWidth-1:0] if_pc_in;
    logic                    if_rdy_out;
    logic [IDWidth-1:0]      if_inst_out;
    logic                    mem_en_out;
    logic [AddressWidth-1:0] mem_addr_out;
    logic                    mem_rdy_in;
    logic [IDWidth-1:0]      mem_inst_in;

    modport slave (
        input  if_en_in, if_pc_in, mem_rdy_in, mem_inst_in,
        output if_rdy_out, if_inst_out, mem_en_out, mem_addr_out
    );

    modport master (
        output if_en_in, if_pc_in, mem_rdy_in, mem_inst_in,
        input  if_rdy_out, if_inst_out, mem_en_out, mem_addr_out
    );

endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays: combinational read, synchronous write,
// valid bits cleared by async reset.
module icache_store
    import icache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [IDWidth-1:0]    wr_data_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [IDWidth-1:0]    rd_data_o
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [IDWidth-1:0]  data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Payload needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line icache with mispredict abort.
// Define ICACHE_STAT_EN to add hit/miss counter outputs.
module icache
    import icache_pkg::*;
(
    input  logic    clk_in,
    input  logic    rst_n_in,
    input  logic    rdy_in,
    input  logic    clear_in,
    icache_if.slave bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt_out,
    output logic [31:0] miss_cnt_out
`endif
);

    icache_state_e           state_q, state_d;
    logic                    rdy_q, rdy_d;
    logic [IDWidth-1:0]      inst_q, inst_d;
    logic                    men_q, men_d;
    logic [AddressWidth-1:0] addr_q, addr_d;

    logic                    we;
    logic                    hit_ev, miss_ev;
    logic                    rd_valid;
    logic [TAG_BITS-1:0]     rd_tag;
    logic [IDWidth-1:0]      rd_data;
    logic                    hit, req;
    logic                    unused_bits;

    assign req = bus.if_en_in && !clear_in;
    assign hit = rd_valid
              && (rd_tag == bus.if_pc_in[AddressWidth-1:INDEX_BITS+2]);
    assign unused_bits = ^{bus.if_pc_in[1:0], addr_q[1:0]};

    icache_store u_store (
        .clk_i      (clk_in),
        .rst_ni     (rst_n_in),
        .we_i       (we),
        .rd_idx_i   (bus.if_pc_in[INDEX_BITS+1:2]),
        .wr_idx_i   (addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (addr_q[AddressWidth-1:INDEX_BITS+2]),
        .wr_data_i  (bus.mem_inst_in),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        inst_d  = inst_q;
        men_d   = men_q;
        addr_d  = addr_q;
        we      = 1'b0;
        hit_ev  = 1'b0;
        miss_ev = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (req && hit) begin
                        inst_d  = rd_data;
                        rdy_d   = 1'b1;
                        state_d = ICACHE_RESP;
                        hit_ev  = 1'b1;
                    end else if (req) begin
                        men_d   = 1'b1;
                        addr_d  = {bus.if_pc_in[AddressWidth-1:2], 2'b00};
                        state_d = ICACHE_MISS;
                        miss_ev = 1'b1;
                    end
                end
                ICACHE_MISS: begin
                    if (bus.mem_rdy_in) begin
                        we    = 1'b1;
                        men_d = 1'b0;
                    end
                    // A flush wins over a same-cycle fill; the fill still lands.
                    if (clear_in) begin
                        state_d = ICACHE_ABORT;
                    end else if (bus.mem_rdy_in) begin
                        inst_d  = bus.mem_inst_in;
                        rdy_d   = 1'b1;
                        state_d = ICACHE_RESP;
                    end
                end
                ICACHE_ABORT: begin
                    if (!men_q) begin
                        state_d = ICACHE_IDLE;
                    end else if (bus.mem_rdy_in) begin
                        we      = 1'b1;
                        men_d   = 1'b0;
                        state_d = ICACHE_IDLE;
                    end
                end
                ICACHE_RESP: begin
                    rdy_d   = 1'b0;
                    state_d = ICACHE_IDLE;
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ICACHE_IDLE;
            rdy_q   <= 1'b0;
            inst_q  <= '0;
            men_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            inst_q  <= inst_d;
            men_q   <= men_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.if_rdy_out   = rdy_q;
    assign bus.if_inst_out  = inst_q;
    assign bus.mem_en_out   = men_q;
    assign bus.mem_addr_out = addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_q + {31'b0, hit_ev};
            miss_cnt_q <= miss_cnt_q + {31'b0, miss_ev};
        end
    end

    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = hit_ev ^ miss_ev;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed scenarios then random fetches
// checked against an address-level cache model and a RAM responder.
module tb_icache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst_n, rdy, clear;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_if bus ();

    icache dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear_in (clear),
        .bus      (bus)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt_out  (hit_cnt),
        .miss_cnt_out (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_mem[$];
    logic [31:0] line_addr[int];
    int          resp_delay;
    int          m_hits, m_miss;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memv(input logic [31:0] a);
        if (a == 32'h1000) return 32'h0000_0013;
        if (a == 32'h1100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = line_of(a);
        return line_addr.exists(idx) && line_addr[idx] == a;
    endfunction

    // RAM controller model: answers each request after resp_delay cycles.
    initial begin
        logic [31:0] a;
        bit          ab;
        int          d;
        bus.mem_rdy_in  = 1'b0;
        bus.mem_inst_in = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_en_out) begin
                a  = bus.mem_addr_out;
                ab = 1'b0;
                d  = resp_delay;
                if (exp_mem.size() == 0)
                    chk("mem_unexpected_req", a, 32'hFFFF_FFFF);
                else
                    chk("mem_req_addr", a, exp_mem.pop_front());
                for (int i = 1; i <= d; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        ab = 1'b1;
                        break;
                    end
                    chk("mem_hold_en", {31'b0, bus.mem_en_out}, 32'd1);
                    chk("mem_hold_addr", bus.mem_addr_out, a);
                end
                if (!ab) begin
                    bus.mem_rdy_in  = 1'b1;
                    bus.mem_inst_in = memv(a);
                    do @(posedge clk); while (!rdy);
                    @(negedge clk);
                    bus.mem_rdy_in = 1'b0;
                    chk("mem_drop", {31'b0, bus.mem_en_out}, 32'd0);
                end
            end
        end
    end

    // Monitor: one scoreboard pop per if_rdy_out pulse.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.if_rdy_out && !prev) begin
                if (exp_q.size() == 0)
                    chk("unexpected_rdy", bus.if_inst_out, 32'hFFFF_FFFF);
                else
                    chk("inst", bus.if_inst_out, exp_q.pop_front());
            end
            prev = bus.if_rdy_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic fetch(input logic [31:0] pc, input int clr);
        bit hit;
        int t;
        hit = model_hit(pc);
        if (hit) begin
            m_hits++;
            exp_q.push_back(memv(pc));
        end else begin
            m_miss++;
            exp_mem.push_back(pc);
            if (clr < 0) exp_q.push_back(memv(pc));
        end
        @(negedge clk);
        bus.if_en_in = 1'b1;
        bus.if_pc_in = pc;
        @(negedge clk);
        if (hit) begin
            chk("hit_latency", {31'b0, bus.if_rdy_out}, 32'd1);
            chk("hit_no_mem", {31'b0, bus.mem_en_out}, 32'd0);
            bus.if_en_in = 1'b0;
            return;
        end
        chk("miss_en", {31'b0, bus.mem_en_out}, 32'd1);
        chk("miss_addr", bus.mem_addr_out, pc);
        chk("miss_no_rdy", {31'b0, bus.if_rdy_out}, 32'd0);
        if (clr < 0) begin
            t = 0;
            while (!bus.if_rdy_out && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("miss_resp", {31'b0, bus.if_rdy_out}, 32'd1);
            bus.if_en_in = 1'b0;
        end else begin
            for (int i = 0; i < clr; i++) @(negedge clk);
            clear = 1'b1;
            bus.if_en_in = 1'b0;
            @(negedge clk);
            clear = 1'b0;
            t = 0;
            while (bus.mem_en_out && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("abort_drop", {31'b0, bus.mem_en_out}, 32'd0);
            repeat (2) @(negedge clk);
        end
        line_addr[line_of(pc)] = pc;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_rdy"}, {31'b0, bus.if_rdy_out}, 32'd0);
        chk({nm, "_inst"}, bus.if_inst_out, 32'd0);
        chk({nm, "_men"}, {31'b0, bus.mem_en_out}, 32'd0);
        chk({nm, "_maddr"}, bus.mem_addr_out, 32'd0);
`ifdef ICACHE_STAT_EN
        chk({nm, "_hits"}, hit_cnt, 32'd0);
        chk({nm, "_misses"}, miss_cnt, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] pc;
        int          len, clr, t;
        rst_n = 1'b1;
        rdy   = 1'b1;
        clear = 1'b0;
        bus.if_en_in = 1'b0;
        bus.if_pc_in = '0;
        resp_delay   = 3;
        m_hits = 0;
        m_miss = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, hit, conflict eviction and refetch.
        resp_delay = 6;
        fetch(32'h1000, -1);
        fetch(32'h1000, -1);
        resp_delay = 3;
        fetch(32'h1100, -1);
        fetch(32'h1000, -1);

        // Flush mid-miss; the line is still filled.
        resp_delay = 4;
        fetch(32'h2000, 2);
        fetch(32'h2000, -1);
`ifdef ICACHE_STAT_EN
        chk("stat_hits_dir", hit_cnt, 32'd2);
        chk("stat_miss_dir", miss_cnt, 32'd4);
`endif

        // clear_in while idle masks the request for that cycle.
        exp_q.push_back(memv(32'h2000));
        m_hits++;
        @(negedge clk);
        bus.if_en_in = 1'b1;
        bus.if_pc_in = 32'h2000;
        clear = 1'b1;
        @(negedge clk);
        chk("idle_clr_rdy", {31'b0, bus.if_rdy_out}, 32'd0);
        chk("idle_clr_mem", {31'b0, bus.mem_en_out}, 32'd0);
        clear = 1'b0;
        @(negedge clk);
        chk("idle_clr_hit", {31'b0, bus.if_rdy_out}, 32'd1);
        bus.if_en_in = 1'b0;

        // Stall for 3 cycles in the response cycle.
        exp_q.push_back(memv(32'h2000));
        m_hits++;
        @(negedge clk);
        bus.if_en_in = 1'b1;
        @(negedge clk);
        chk("resp_stall_hit", {31'b0, bus.if_rdy_out}, 32'd1);
        bus.if_en_in = 1'b0;
        rdy = 1'b0;
        len = 1;
        repeat (3) begin
            @(negedge clk);
            if (bus.if_rdy_out) len++;
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("resp_stall_len", 32'(len), 32'd4);
        chk("resp_stall_end", {31'b0, bus.if_rdy_out}, 32'd0);

        // Stall for 3 cycles while the miss is outstanding.
        resp_delay = 6;
        exp_mem.push_back(32'h3000);
        exp_q.push_back(memv(32'h3000));
        m_miss++;
        @(negedge clk);
        bus.if_en_in = 1'b1;
        bus.if_pc_in = 32'h3000;
        @(negedge clk);
        chk("miss_stall_req", {31'b0, bus.mem_en_out}, 32'd1);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("miss_stall_en", {31'b0, bus.mem_en_out}, 32'd1);
            chk("miss_stall_rdy", {31'b0, bus.if_rdy_out}, 32'd0);
        end
        rdy = 1'b1;
        t = 0;
        while (!bus.if_rdy_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus.if_en_in = 1'b0;
        len = 0;
        while (bus.if_rdy_out && len < 10) begin
            @(negedge clk);
            len++;
        end
        chk("miss_stall_pulse", 32'(len), 32'd1);
        line_addr[line_of(32'h3000)] = 32'h3000;

        // Async reset while a miss is outstanding.
        resp_delay = 20;
        exp_mem.push_back(32'h4000);
        @(negedge clk);
        bus.if_en_in = 1'b1;
        bus.if_pc_in = 32'h4000;
        @(negedge clk);
        chk("rst_miss_req", {31'b0, bus.mem_en_out}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.if_en_in = 1'b0;
        #1 chk_reset_outs("midmiss_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        line_addr.delete();
        m_hits = 0;
        m_miss = 0;
        resp_delay = 3;
        fetch(32'h1000, -1);

        // Random fetches over a few lines and conflicting tags.
        repeat (200) begin
            pc = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h100
               + 32'($urandom_range(0, 7)) * 32'd4;
            resp_delay = int'($urandom_range(1, 5));
            clr = ($urandom_range(0, 9) == 0)
                ? int'($urandom_range(0, resp_delay)) : -1;
            fetch(pc, clr);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
`ifdef ICACHE_STAT_EN
        chk("stat_hits_final", hit_cnt, 32'(m_hits));
        chk("stat_miss_final", miss_cnt, 32'(m_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-instruction-per-line instruction cache between the fetch stage and the RAM controller's instruction port.
- Serves hits with one-cycle latency.
- On a miss, issues a single 32-bit fetch on the RAM controller instruction interface, fills the line, then responds.
- Supports a pipeline clear for branch mispredicts without breaking the RAM controller's hold-inputs-stable contract.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines); index = pc[INDEX_BITS+1:2].
- TAG_BITS, `AddressWidth-INDEX_BITS-2, tag width; tag = pc[`AddressWidth-1:INDEX_BITS+2].

Ports:
- clk_in  input  1  clock, all state on posedge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- clear_in  input  1  fetch flush (mispredict); cancels the outstanding fetch response.
- if_en_in  input  1  fetch request; held with if_pc_in until if_rdy_out or clear_in.
- if_pc_in  input  `AddressWidth  fetch address, 4-byte aligned.
- if_rdy_out  output  1  one-cycle pulse: if_inst_out valid.
- if_inst_out  output  `IDWidth  fetched instruction.
- mem_en_out  output  1  instruction read request to the RAM controller.
- mem_addr_out  output  `AddressWidth  address of the miss; stable while mem_en_out is high.
- mem_rdy_in  input  1  RAM controller instruction-ready pulse.
- mem_inst_in  input  `IDWidth  RAM controller instruction data, valid with mem_rdy_in.

Behaviour:
- Reset (rst_n_in low, async):
  - all valid bits 0; state IDLE.
  - if_rdy_out 0, if_inst_out 0, mem_en_out 0, mem_addr_out 0.
- States: IDLE, MISS, ABORT, RESP.
- IDLE, with if_en_in=1 and clear_in=0:
  - Combinational lookup at index.
  - Hit (valid && tag match): at the edge, if_inst_out<=data, if_rdy_out<=1, go to RESP. Latency is 1 cycle.
  - Miss: at the edge, mem_en_out<=1, mem_addr_out<={pc[31:2],2'b00}, go to MISS.
- RESP:
  - if_rdy_out is high for exactly this cycle; the request is not re-sampled.
  - At the next edge, if_rdy_out<=0 and go to IDLE.
  - Maximum throughput is one hit per 2 cycles.
- MISS:
  - mem_en_out and mem_addr_out hold until mem_rdy_in=1.
  - On that edge:
    - write line (valid=1, tag, mem_inst_in) and set mem_en_out<=0.
    - if_inst_out<=mem_inst_in and if_rdy_out<=1, go to RESP.
- MISS with clear_in=1 (including clear_in and mem_rdy_in in the same cycle): go to ABORT; mem_en_out keeps its hold/drop rule unchanged.
- ABORT:
  - Hold mem_en_out/mem_addr_out until mem_rdy_in.
  - On mem_rdy_in, still fill the line (the data is correct for that address), drop mem_en_out, go to IDLE.
  - if_rdy_out is never asserted.
- clear_in in IDLE: the request is ignored that cycle.
- clear_in in RESP: if_rdy_out<=0 immediately at the next edge (same as normal); no extra action.
- mem_en_out deasserts on the same edge mem_rdy_in is sampled, so the RAM controller sees it low when it returns to idle. No back-to-back request is issued in the following cycle; the RESP/IDLE sequencing guarantees this.
- rdy_in=0: state, arrays and outputs frozen; a pending mem_en_out stays asserted.
- Reset mid-miss: the request is dropped, and the RAM controller is reset by the same system reset.
- No self-modifying code support: the array is never invalidated except by reset.

Optional Feature:
- Macro ICACHE_STAT_EN.
- When defined:
  - adds output ports hit_cnt_out[31:0] and miss_cnt_out[31:0], reset to 0.
  - hit_cnt_out increments on each IDLE hit.
  - miss_cnt_out increments on each IDLE miss (MISS or later ABORT).
  - both counters wrap at 2^32 and freeze while rdy_in=0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- constant.vh: `AddressWidth, `IDWidth, and the icache state encodings (ICACHE_IDLE/MISS/ABORT/RESP, 2 bits).
- One sub-module, icache_store:
  - valid/tag/data arrays with combinational read by index.
  - synchronous write port.
  - async active-low clear of the valid bits.

Test Plan:
- Cold miss: if_pc_in=0x1000, mem_rdy_in pulses with 0x00000013 after 6 cycles -> mem_en_out high with addr 0x1000 until that edge; if_rdy_out pulses once with 0x00000013; mem_en_out is low in the following cycle.
- Hit: re-request 0x1000 -> if_rdy_out next cycle with 0x00000013; mem_en_out stays 0.
- Conflict: request 0x1100 (same index with INDEX_BITS=6) -> miss; after a fill of 0xDEADBEEF, 0x1000 misses again.
- Clear mid-miss: clear_in pulses during MISS for 0x2000 -> no if_rdy_out; mem_en_out held until mem_rdy_in; a subsequent 0x2000 request hits.
- rdy_in low for 3 cycles during RESP and during MISS -> if_rdy_out pulse is stretched by exactly the stall; no state change.
- ICACHE_STAT_EN: the sequence above -> hit_cnt_out=2, miss_cnt_out=4; async reset mid-miss -> all outputs 0 and a subsequent hit on 0x1000 misses.
